ciclo_secuenciador: RTL and testbench

//  Program sequencer for the washer datapath: walks FILL/WASH/DRAIN/RINSE/SPIN/BUZZ phases
//  per a user-selected program, timing each phase from a 1 s tick. Drives motor, valve,

---
 rtl/ciclo_secuenciador_if.sv | 30 +++
 rtl/ciclo_secuenciador.sv | 178 +++++++++++++++++
 tb/tb_ciclo_secuenciador.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ciclo_secuenciador_if.sv
// Front-panel and actuator signal bundle for the washer program sequencer.
// The sequencer uses the slave view; the panel/driver side uses the master view.
interface ciclo_secuenciador_if #(
  parameter int unsigned TW = 6
) ();
  logic          tick_1s;
  logic          start;
  logic          pause;
  logic          door_closed;
  logic [1:0]    mode;
  logic          motor;
  logic [1:0]    valve;
  logic          heater;
  logic          buzzer;
  logic          door_lock;
  logic          busy;
  logic [2:0]    phase;
  logic [TW-1:0] remaining;
  logic          error;

  modport slave (
    input  tick_1s, start, pause, door_closed, mode,
    output motor, valve, heater, buzzer, door_lock, busy, phase, remaining, error
  );

  modport master (
    output tick_1s, start, pause, door_closed, mode,
    input  motor, valve, heater, buzzer, door_lock, busy, phase, remaining, error
  );
endinterface

// File: rtl/ciclo_secuenciador.sv
// Washer program sequencer: steps FILL/WASH/DRAIN/RINSE/SPIN/BUZZ from a 1 s tick,
// with pause freeze and a door interlock that aborts into a sticky error.
module ciclo_secuenciador #(
  parameter int unsigned FILL_TIME    = 5,
  parameter int unsigned WASH_TIME    = 20,
  parameter int unsigned RINSE_TIME   = 10,
  parameter int unsigned DRAIN_TIME   = 5,
  parameter int unsigned SPIN_TIME    = 30,
  parameter int unsigned BUZZ_TIME    = 2,
  parameter int unsigned RINSE_CYCLES = 2,
  parameter int unsigned TW           = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  ciclo_secuenciador_if.slave  bus
);

  localparam int unsigned CW = $clog2(RINSE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_DRAIN = 3'd4,
    S_SPIN  = 3'd5,
    S_BUZZ  = 3'd6
  } state_t;

  state_t        st, st_n, nxt_ph;
  logic [TW-1:0] tmr, tmr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          paused, paused_n;
  logic          err_n;
  logic [1:0]    mode_r, mode_n;
  logic          wash_done, wash_done_n;
  logic          from_wash, from_wash_n;
  logic          run_n;

  function automatic logic [TW-1:0] time_of(input state_t s);
    case (s)
      S_FILL:  return TW'(FILL_TIME);
      S_WASH:  return TW'(WASH_TIME);
      S_RINSE: return TW'(RINSE_TIME);
      S_DRAIN: return TW'(DRAIN_TIME);
      S_SPIN:  return TW'(SPIN_TIME);
      S_BUZZ:  return TW'(BUZZ_TIME);
      default: return '0;
    endcase
  endfunction

  // Phase that follows the current one when its timer expires
  always_comb begin
    nxt_ph = S_IDLE;
    case (st)
      S_FILL:  nxt_ph = (mode_r == 2'd0 && !wash_done) ? S_WASH : S_RINSE;
      S_WASH:  nxt_ph = S_DRAIN;
      S_RINSE: nxt_ph = S_DRAIN;
      S_DRAIN: nxt_ph = (from_wash || (32'(cnt) + 32'd1 < RINSE_CYCLES)) ? S_FILL : S_SPIN;
      S_SPIN:  nxt_ph = S_BUZZ;
      default: nxt_ph = S_IDLE;
    endcase
  end

  // Next-state logic: abort beats pause, pause beats tick
  always_comb begin
    st_n        = st;
    tmr_n       = tmr;
    cnt_n       = cnt;
    paused_n    = paused;
    err_n       = bus.error;
    mode_n      = mode_r;
    wash_done_n = wash_done;
    from_wash_n = from_wash;
    case (st)
      S_IDLE: begin
        paused_n = 1'b0;
        tmr_n    = '0;
        if (bus.start && bus.door_closed && bus.mode != 2'd3) begin
          mode_n      = bus.mode;
          err_n       = 1'b0;
          cnt_n       = '0;
          wash_done_n = 1'b0;
          from_wash_n = 1'b0;
          st_n        = (bus.mode == 2'd2) ? S_SPIN : S_FILL;
          tmr_n       = time_of(st_n);
        end
      end
      S_BUZZ: begin
        paused_n = 1'b0;
        if (bus.tick_1s) begin
          if (tmr == TW'(1)) begin
            st_n  = S_IDLE;
            tmr_n = '0;
          end else begin
            tmr_n = tmr - TW'(1);
          end
        end
      end
      S_FILL, S_WASH, S_RINSE, S_DRAIN, S_SPIN: begin
        if (!bus.door_closed) begin
          st_n     = S_IDLE;
          err_n    = 1'b1;
          tmr_n    = '0;
          paused_n = 1'b0;
        end else begin
          paused_n = bus.pause;
          if (bus.tick_1s && !paused) begin
            if (tmr == TW'(1)) begin
              st_n  = nxt_ph;
              tmr_n = time_of(nxt_ph);
              if (st == S_WASH) begin
                wash_done_n = 1'b1;
                from_wash_n = 1'b1;
              end
              if (st == S_DRAIN) begin
                from_wash_n = 1'b0;
                if (!from_wash) cnt_n = cnt + CW'(1);
              end
            end else begin
              tmr_n = tmr - TW'(1);
            end
          end
        end
      end
      default: begin
        st_n     = S_IDLE;
        tmr_n    = '0;
        paused_n = 1'b0;
      end
    endcase
  end

  assign run_n = !paused_n;

  // State registers plus outputs decoded from the next state so they stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= S_IDLE;
      tmr           <= '0;
      cnt           <= '0;
      paused        <= 1'b0;
      mode_r        <= 2'd0;
      wash_done     <= 1'b0;
      from_wash     <= 1'b0;
      bus.error     <= 1'b0;
      bus.motor     <= 1'b0;
      bus.valve     <= 2'd2;
      bus.heater    <= 1'b0;
      bus.buzzer    <= 1'b0;
      bus.door_lock <= 1'b0;
      bus.busy      <= 1'b0;
      bus.phase     <= 3'd0;
      bus.remaining <= '0;
    end else begin
      st            <= st_n;
      tmr           <= tmr_n;
      cnt           <= cnt_n;
      paused        <= paused_n;
      mode_r        <= mode_n;
      wash_done     <= wash_done_n;
      from_wash     <= from_wash_n;
      bus.error     <= err_n;
      bus.motor     <= run_n && (st_n == S_WASH || st_n == S_RINSE || st_n == S_SPIN);
      bus.heater    <= run_n && (st_n == S_WASH);
      bus.valve     <= !run_n ? 2'd2 :
                       (st_n == S_FILL) ? 2'd0 :
                       (st_n == S_DRAIN || st_n == S_SPIN) ? 2'd1 : 2'd2;
      bus.buzzer    <= (st_n == S_BUZZ);
      bus.door_lock <= (st_n == S_FILL || st_n == S_WASH || st_n == S_RINSE ||
                        st_n == S_DRAIN || st_n == S_SPIN);
      bus.busy      <= (st_n != S_IDLE);
      bus.phase     <= 3'(st_n);
      bus.remaining <= tmr_n;
    end
  end

endmodule

// File: tb/tb_ciclo_secuenciador.sv
// Bench for ciclo_secuenciador: directed scenarios then random stimulus, every cycle
// compared against a program-list reference model.
module tb_ciclo_secuenciador;
  localparam int unsigned TW = 6;

  logic clk = 1'b0;
  logic rst;

  ciclo_secuenciador_if #(.TW(TW)) bus ();

  ciclo_secuenciador #(
    .FILL_TIME(2), .WASH_TIME(3), .RINSE_TIME(2), .DRAIN_TIME(1),
    .SPIN_TIME(2), .BUZZ_TIME(1), .RINSE_CYCLES(2), .TW(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;

  // Reference model: the remaining program as a list of (phase, ticks)
  int q_ph[$];
  int q_t[$];
  bit m_busy, m_paused, m_err;
  int m_rem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void add(input int ph, input int t);
    q_ph.push_back(ph);
    q_t.push_back(t);
  endfunction

  function automatic void load_prog(input int md);
    q_ph.delete();
    q_t.delete();
    if (md == 0) begin add(1, 2); add(2, 3); add(4, 1); end
    if (md != 2) for (int r = 0; r < 2; r++) begin add(1, 2); add(3, 2); add(4, 1); end
    add(5, 2);
    add(6, 1);
  endfunction

  function automatic int m_phase();
    return m_busy ? q_ph[0] : 0;
  endfunction

  function automatic void advance();
    if (m_rem == 1) begin
      void'(q_ph.pop_front());
      void'(q_t.pop_front());
      if (q_ph.size() == 0) begin m_busy = 0; m_rem = 0; end
      else m_rem = q_t[0];
    end else begin
      m_rem--;
    end
  endfunction

  task automatic model_step();
    bit was;
    if (rst) begin
      m_busy = 0; m_paused = 0; m_err = 0; m_rem = 0;
    end else if (!m_busy) begin
      if (bus.start && bus.door_closed && bus.mode != 2'd3) begin
        load_prog(int'(bus.mode));
        m_busy = 1; m_rem = q_t[0]; m_err = 0; m_paused = 0;
      end
    end else if (q_ph[0] != 6) begin
      if (!bus.door_closed) begin
        m_busy = 0; m_err = 1; m_rem = 0; m_paused = 0;
      end else begin
        was = m_paused;
        m_paused = bus.pause;
        if (bus.tick_1s && !was) advance();
      end
    end else begin
      m_paused = 0;
      if (bus.tick_1s) advance();
    end
  endtask

  task automatic check_all();
    int ph;
    bit run;
    ph  = m_phase();
    run = !m_paused;
    chk("phase", 32'(bus.phase), ph);
    chk("remaining", 32'(bus.remaining), m_rem);
    chk("busy", 32'(bus.busy), 32'(ph != 0));
    chk("motor", 32'(bus.motor), 32'(run && (ph == 2 || ph == 3 || ph == 5)));
    chk("heater", 32'(bus.heater), 32'(run && ph == 2));
    chk("valve", 32'(bus.valve), !run ? 2 : (ph == 1) ? 0 : (ph == 4 || ph == 5) ? 1 : 2);
    chk("buzzer", 32'(bus.buzzer), 32'(ph == 6));
    chk("door_lock", 32'(bus.door_lock), 32'(ph >= 1 && ph <= 5));
    chk("error", 32'(bus.error), 32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Cycles with a tick every fourth clock
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1s = (tcnt % 4 == 3);
      tcnt++;
      cyc();
    end
    bus.tick_1s = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.tick_1s = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until(input int ph, input int limit, input string tag);
    int k;
    k = 0;
    while (int'(bus.phase) != ph && k < limit) begin adv(1); k++; end
    chk(tag, 32'(bus.phase), ph);
  endtask

  initial begin
    int seq[$];
    int cnts[$];
    int exp_seq[12];
    int exp_cnt[11];
    int c, prev, sum;
    bit tk;
    exp_seq = '{1, 2, 4, 1, 3, 4, 1, 3, 4, 5, 6, 0};
    exp_cnt = '{2, 3, 1, 2, 2, 1, 2, 2, 1, 2, 1};

    rst = 1'b1;
    bus.tick_1s = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.door_closed = 1'b1; bus.mode = 2'd0;
    idle(2);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_valve", 32'(bus.valve), 2);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_lock", 32'(bus.door_lock), 0);
    rst = 1'b0;
    idle(1);

    // Full program: phase order and tick counts per phase
    bus.mode = 2'd0; bus.start = 1'b1; idle(1); bus.start = 1'b0;
    chk("t1_start", 32'(bus.phase), 1);
    seq.push_back(int'(bus.phase));
    c = 0;
    for (int k = 0; k < 300 && bus.phase != 3'd0; k++) begin
      prev = int'(bus.phase);
      tk = (tcnt % 4 == 3);
      adv(1);
      if (tk) c++;
      if (int'(bus.phase) != prev) begin
        cnts.push_back(c);
        seq.push_back(int'(bus.phase));
        c = 0;
      end
    end
    chk("t1_nphases", seq.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < seq.size()) chk($sformatf("t1_seq%0d", i), seq[i], exp_seq[i]);
    sum = 0;
    for (int i = 0; i < 11; i++)
      if (i < cnts.size()) begin
        chk($sformatf("t1_ticks%0d", i), cnts[i], exp_cnt[i]);
        sum += cnts[i];
      end
    chk("t1_total_ticks", sum, 19);

    // Spin-only program
    bus.mode = 2'd2; bus.start = 1'b1; idle(1); bus.start = 1'b0;
    chk("t2_spin", 32'(bus.phase), 5);
    chk("t2_motor", 32'(bus.motor), 1);
    chk("t2_valve", 32'(bus.valve), 1);
    run_until(6, 50, "t2_buzz");
    chk("t2_buzzer", 32'(bus.buzzer), 1);
    run_until(0, 50, "t2_idle");
    chk("t2_end_motor", 32'(bus.motor), 0);
    chk("t2_end_valve", 32'(bus.valve), 2);
    chk("t2_end_buzzer", 32'(bus.buzzer), 0);
    chk("t2_end_lock", 32'(bus.door_lock), 0);
    chk("t2_end_rem", 32'(bus.remaining), 0);

    // Pause mid-wash
    bus.mode = 2'd0; bus.start = 1'b1; idle(1); bus.start = 1'b0;
    run_until(2, 100, "t3_wash");
    for (int k = 0; k < 20 && bus.remaining != 6'd2; k++) adv(1);
    chk("t3_rem2", 32'(bus.remaining), 2);
    bus.pause = 1'b1;
    adv(20);
    chk("t3_p_motor", 32'(bus.motor), 0);
    chk("t3_p_heater", 32'(bus.heater), 0);
    chk("t3_p_valve", 32'(bus.valve), 2);
    chk("t3_p_rem", 32'(bus.remaining), 2);
    chk("t3_p_lock", 32'(bus.door_lock), 1);
    bus.pause = 1'b0;
    idle(2);
    chk("t3_r_motor", 32'(bus.motor), 1);
    chk("t3_r_heater", 32'(bus.heater), 1);
    c = 0;
    for (int k = 0; k < 100 && bus.phase == 3'd2; k++) begin
      tk = (tcnt % 4 == 3);
      adv(1);
      if (tk) c++;
    end
    chk("t3_ticks_after", c, 2);
    chk("t3_drain", 32'(bus.phase), 4);

    // Door opened during rinse
    run_until(3, 100, "t4_rinse");
    bus.door_closed = 1'b0;
    idle(1);
    chk("t4_phase", 32'(bus.phase), 0);
    chk("t4_error", 32'(bus.error), 1);
    chk("t4_motor", 32'(bus.motor), 0);
    chk("t4_valve", 32'(bus.valve), 2);
    chk("t4_lock", 32'(bus.door_lock), 0);
    bus.door_closed = 1'b1;
    idle(1);
    bus.mode = 2'd2; bus.start = 1'b1; idle(1); bus.start = 1'b0;
    chk("t4_err_clr", 32'(bus.error), 0);
    chk("t4_restart", 32'(bus.phase), 5);
    run_until(0, 50, "t4_done");

    // Rejected starts, and start/mode activity while busy
    bus.door_closed = 1'b0; bus.mode = 2'd0; bus.start = 1'b1;
    idle(3);
    chk("t5_door_busy", 32'(bus.busy), 0);
    bus.door_closed = 1'b1; bus.mode = 2'd3;
    idle(3);
    chk("t5_mode3_busy", 32'(bus.busy), 0);
    chk("t5_mode3_phase", 32'(bus.phase), 0);
    bus.start = 1'b0;
    bus.mode = 2'd2; bus.start = 1'b1; idle(1); bus.start = 1'b0;
    chk("t5_spin", 32'(bus.phase), 5);
    adv(2);
    bus.start = 1'b1; bus.mode = 2'd0;
    adv(2);
    bus.start = 1'b0;
    run_until(6, 50, "t5_buzz");
    run_until(0, 50, "t5_idle");

    // Reset during drain together with tick and open door
    bus.mode = 2'd0; bus.start = 1'b1; idle(1); bus.start = 1'b0;
    run_until(4, 100, "t6_drain");
    rst = 1'b1; bus.tick_1s = 1'b1; bus.door_closed = 1'b0;
    cyc();
    chk("t6_phase", 32'(bus.phase), 0);
    chk("t6_rem", 32'(bus.remaining), 0);
    chk("t6_error", 32'(bus.error), 0);
    chk("t6_valve", 32'(bus.valve), 2);
    chk("t6_lock", 32'(bus.door_lock), 0);
    rst = 1'b0; bus.tick_1s = 1'b0; bus.door_closed = 1'b1;
    idle(1);

    // Random traffic against the model
    for (int k = 0; k < 2500; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.start = ($urandom_range(0, 15) == 0);
      bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) bus.pause = !bus.pause;
      bus.door_closed = ($urandom_range(0, 149) != 0);
      bus.tick_1s = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
